// File: rtl/sw_pkg.sv
// Shared constants and FSM state type for the FASTA sequence feeder.
package sw_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_GT = 8'h3E;

    localparam logic [1:0] CODE_A = 2'b10;
    localparam logic [1:0] CODE_G = 2'b11;
    localparam logic [1:0] CODE_T = 2'b00;
    localparam logic [1:0] CODE_C = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        Q_HDR,
        Q_SEQ,
        D_WAIT,
        D_HDR,
        D_SEQ,
        D_GAP
    } state_t;

endpackage

// File: rtl/seq_feeder_if.sv
// Character stream handshake into the feeder: source drives char_in/char_valid, feeder returns char_ready.
interface seq_feeder_if;

    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );

endinterface

// File: rtl/base_encoder.sv
// Combinational ASCII nucleotide to 2-bit code mapper.
// Lower-case a/c/g/t are accepted only when SEQ_FEEDER_LOWERCASE_EN is defined.
module base_encoder
    import sw_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_base,
    output logic [1:0] code
);

    logic [7:0] ch;

    always_comb begin
`ifdef SEQ_FEEDER_LOWERCASE_EN
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            ch = char_in - 8'h20;
        end else begin
            ch = char_in;
        end
`else
        ch = char_in;
`endif
        is_base = 1'b1;
        code    = CODE_T;
        case (ch)
            8'h41:   code = CODE_A;
            8'h43:   code = CODE_C;
            8'h47:   code = CODE_G;
            8'h54:   code = CODE_T;
            default: is_base = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_feeder.sv
// FASTA parser: packs the first record as the query, then streams database bases to the scoring array.
// Build option SEQ_FEEDER_LOWERCASE_EN (in base_encoder) accepts lower-case bases.
module seq_feeder
    import sw_pkg::*;
#(
    parameter int LENGTH     = 128,
    parameter int LOG_LENGTH = 7,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_feeder_if.slave           char_if,
    input  logic                  new_query,
    output logic [2*LENGTH-1:0]   query,
    output logic [LOG_LENGTH:0]   query_len,
    output logic                  query_vld,
    output logic [1:0]            data_out,
    output logic                  en_out,
    output logic [15:0]           seq_id,
    output logic                  err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LOG_LENGTH:0] LEN_MAX  = (LOG_LENGTH+1)'(LENGTH);
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t                state_q, state_d;
    logic [2*LENGTH-1:0]   query_q, query_d;
    logic [LOG_LENGTH:0]   query_len_q, query_len_d;
    logic                  query_vld_q, query_vld_d;
    logic [1:0]            data_out_q, data_out_d;
    logic                  en_out_q, en_out_d;
    logic [15:0]           seq_id_q, seq_id_d;
    logic                  err_q, err_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  db_any_q, db_any_d;

    logic                  is_base;
    logic [1:0]            code;
    logic                  accept;
    logic                  is_lf, is_cr, is_gt;
    logic [LOG_LENGTH+1:0] wr_shift;

    base_encoder u_enc (
        .char_in (char_if.char_in),
        .is_base (is_base),
        .code    (code)
    );

    assign char_if.char_ready = !rst && (state_q != D_GAP);
    assign accept   = char_if.char_valid && char_if.char_ready;
    assign is_lf    = (char_if.char_in == ASCII_LF);
    assign is_cr    = (char_if.char_in == ASCII_CR);
    assign is_gt    = (char_if.char_in == ASCII_GT);
    // Slots above query_len are always zero, so a shifted OR inserts the new base.
    assign wr_shift = {query_len_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        query_d     = query_q;
        query_len_d = query_len_q;
        query_vld_d = query_vld_q;
        data_out_d  = data_out_q;
        en_out_d    = 1'b0;
        seq_id_d    = seq_id_q;
        err_d       = err_q;
        gap_cnt_d   = gap_cnt_q;
        db_any_d    = db_any_q;

        if (new_query) begin
            state_d     = IDLE;
            query_d     = '0;
            query_len_d = '0;
            query_vld_d = 1'b0;
            seq_id_d    = '0;
            gap_cnt_d   = '0;
            db_any_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_gt) state_d = Q_HDR;
                end
                Q_HDR: begin
                    if (accept && is_lf) state_d = Q_SEQ;
                end
                Q_SEQ: begin
                    if (accept) begin
                        if (is_lf) begin
                            if (query_len_q != '0) begin
                                query_vld_d = 1'b1;
                                state_d     = D_WAIT;
                            end
                        end else if (is_base) begin
                            if (query_len_q < LEN_MAX) begin
                                query_d     = query_q | ((2*LENGTH)'(code) << wr_shift);
                                query_len_d = query_len_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (!is_cr) begin
                            err_d = 1'b1;
                        end
                    end
                end
                D_WAIT: begin
                    if (accept && is_gt) state_d = D_HDR;
                end
                D_HDR: begin
                    if (accept && is_lf) begin
                        state_d  = D_SEQ;
                        db_any_d = 1'b0;
                    end
                end
                D_SEQ: begin
                    if (accept) begin
                        if (is_lf) begin
                            if (db_any_q) begin
                                state_d   = D_GAP;
                                gap_cnt_d = '0;
                            end
                        end else if (is_base) begin
                            data_out_d = code;
                            en_out_d   = 1'b1;
                            db_any_d   = 1'b1;
                        end else if (!is_cr) begin
                            err_d = 1'b1;
                        end
                    end
                end
                D_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        seq_id_d = seq_id_q + 16'd1;
                        state_d  = D_WAIT;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            query_q     <= '0;
            query_len_q <= '0;
            query_vld_q <= 1'b0;
            data_out_q  <= '0;
            en_out_q    <= 1'b0;
            seq_id_q    <= '0;
            err_q       <= 1'b0;
            gap_cnt_q   <= '0;
            db_any_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            query_q     <= query_d;
            query_len_q <= query_len_d;
            query_vld_q <= query_vld_d;
            data_out_q  <= data_out_d;
            en_out_q    <= en_out_d;
            seq_id_q    <= seq_id_d;
            err_q       <= err_d;
            gap_cnt_q   <= gap_cnt_d;
            db_any_q    <= db_any_d;
        end
    end

    assign query     = query_q;
    assign query_len = query_len_q;
    assign query_vld = query_vld_q;
    assign data_out  = data_out_q;
    assign en_out    = en_out_q;
    assign seq_id    = seq_id_q;
    assign err       = err_q;

endmodule

// File: doc/seq_feeder.md
SEQ_FEEDER -- requirements
Module: seq_feeder

Interface
REQ-001 The block SHALL have parameter LENGTH, default 128, giving the maximum query bases (the systolic array PE count).
REQ-002 The block SHALL have parameter LOG_LENGTH, default 7, giving the query-length counter width minus one.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1, giving the idle cycles inserted between database sequences.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-006 The block SHALL have port char_in, input, 8, the ASCII FASTA character.
REQ-007 The block SHALL have port char_valid, input, 1, qualifying char_in.
REQ-008 The block SHALL have port char_ready, output, 1; a character is consumed when char_valid && char_ready.
REQ-009 The block SHALL have port new_query, input, 1, a synchronous pulse that discards the current query and restarts parsing.
REQ-010 The block SHALL have port query, output, 2*LENGTH, the packed query with base i at bits [2i+1:2i].
REQ-011 The block SHALL have port query_len, output, LOG_LENGTH+1, the number of query bases.
REQ-012 The block SHALL have port query_vld, output, 1, high once the query is complete.
REQ-013 The block SHALL have port data_out, output, 2, the encoded database base to the scoring array data_in.
REQ-014 The block SHALL have port en_out, output, 1, qualifying data_out (the scoring array en_in).
REQ-015 The block SHALL have port seq_id, output, 16, the index of the database sequence being streamed.
REQ-016 The block SHALL have port err, output, 1, sticky, set on an invalid sequence character or query overflow.

Function
REQ-017 The FSM SHALL have states IDLE, Q_HDR, Q_SEQ, D_WAIT, D_HDR, D_SEQ and D_GAP.
REQ-018 IDLE SHALL move to Q_HDR on '>' and discard any other character.
REQ-019 Q_HDR and D_HDR SHALL discard characters up to LF; LF SHALL move Q_HDR to Q_SEQ and D_HDR to D_SEQ.
REQ-020 In Q_SEQ each valid base SHALL be written to query slot query_len and query_len SHALL increment.
REQ-021 In Q_SEQ an LF with query_len>0 SHALL set query_vld and move to D_WAIT; an LF with query_len==0 SHALL be ignored.
REQ-022 In Q_SEQ bases beyond LENGTH SHALL be dropped, set err, and leave query_len at LENGTH.
REQ-023 D_WAIT SHALL move to D_HDR on '>' and discard any other character.
REQ-024 In D_SEQ each valid base SHALL drive data_out=encoding and en_out=1 on the next cycle, a latency of exactly 1.
REQ-025 en_out SHALL be 0 on every cycle without a newly accepted base; downstream applies no backpressure.
REQ-026 In D_SEQ an LF after at least one base SHALL move to D_GAP; an LF after zero bases SHALL be ignored.
REQ-027 D_GAP SHALL hold char_ready=0 and en_out=0 for GAP_CYCLES cycles, then increment seq_id (wrapping 0xFFFF->0) and move to D_WAIT.
REQ-028 char_ready SHALL be 1 in all states except D_GAP and while rst is asserted.
REQ-029 CR (0x0D) SHALL be discarded in every state without setting err.
REQ-030 In Q_SEQ or D_SEQ, any character other than A/C/G/T, LF or CR SHALL be skipped and set err.
REQ-031 Base encoding SHALL be A=2'b10, G=2'b11, T=2'b00, C=2'b01.
REQ-032 new_query SHALL force IDLE; clear query_vld, query_len, query and seq_id; and cancel any D_GAP.
REQ-033 A character accepted in the same cycle as new_query SHALL be dropped; new_query wins.
REQ-034 err SHALL be cleared only by rst.

Reset
REQ-035 While rst is high, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-036 Assertion of rst mid-sequence SHALL abort immediately with no further en_out pulses.

Configuration
REQ-037 With SEQ_FEEDER_LOWERCASE_EN defined, 'a','c','g','t' SHALL be accepted and encoded identically to upper case.
REQ-038 Without SEQ_FEEDER_LOWERCASE_EN, lower-case bases SHALL be treated as invalid characters (skipped, err set).

Structure
REQ-039 Package sw_pkg SHALL hold the base-encoding constants, the ASCII constants (LF, CR, '>') and the FSM state enum.
REQ-040 Sub-module base_encoder SHALL be combinational: char in, {is_base, code[1:0]} out, with the lower-case option inside.

Verification
REQ-041 ">q LF ACGT LF" SHALL produce query_len=4, query[7:0]=8'b00_11_01_10, and query_vld=1 the cycle after the LF.
REQ-042 After a query, ">d LF GATTACA LF" SHALL produce 7 consecutive en_out pulses with data 11,10,00,00,10,01,10, then en_out=0 for GAP_CYCLES cycles with char_ready=0, then seq_id=1.
REQ-043 LENGTH+3 query bases SHALL produce query_len=LENGTH and err=1, with the first LENGTH bases packed.
REQ-044 "ACNT" in a database line SHALL produce 3 en_out pulses (10,01,00) and err=1; "AC\r\nT" SHALL produce no err.
REQ-045 new_query asserted mid-D_SEQ SHALL give, next cycle, state IDLE, query_vld=0, seq_id=0 and no en_out.
REQ-046 rst asserted asynchronously mid-stream SHALL zero all outputs before the next clock edge.
